sev_seg_scan: RTL and testbench

Parametrised, time-multiplexed multi-digit seven-segment driver for the vending machine front panel. It generalises the single-digit combinational state decoder into NUM_DIGITS scanned digits. Added features: 4-bit glyph codes per digit, tear-free double-buffered loads, and per-digit blanking and blinking. It sits between the vending controller, which writes display codes, and the board's shared segment bus and digit-anode lines.

---
 rtl/sev_seg_pkg.sv | 20 ++
 rtl/sev_seg_glyph.sv | 11 +
 rtl/sev_seg_scan.sv | 205 ++++++++++++++++++++
 tb/tb_sev_seg_scan.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// Shared types, glyph codes and the active-high glyph table for the
// scanned seven-segment display driver.
package sev_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam logic [3:0] GLYPH_A     = 4'hA;
    localparam logic [3:0] GLYPH_B     = 4'hB;
    localparam logic [3:0] GLYPH_C     = 4'hC;
    localparam logic [3:0] GLYPH_D     = 4'hD;
    localparam logic [3:0] GLYPH_E     = 4'hE;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    // Segments a..g on bits 0..6, 1 = lit; index is the glyph code.
    localparam seg_t GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h00
    };

endpackage

// File: rtl/sev_seg_glyph.sv
// Combinational glyph decoder: 4-bit display code to active-high segments.
module sev_seg_glyph
    import sev_seg_pkg::*;
(
    input  logic [3:0] code,
    output seg_t       seg_c
);

    assign seg_c = GLYPH_TABLE[code];

endmodule

// File: rtl/sev_seg_scan.sv
// Time-multiplexed multi-digit seven-segment driver with double-buffered
// loads, per-digit blank/blink. Optional decimal point: SEV_SEG_DP_EN.
module sev_seg_scan
    import sev_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned BLINK_FRAMES   = 64,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   char_in,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done,
    output logic                      pending
`ifdef SEV_SEG_DP_EN
    ,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    output logic                      dp
`endif
);

    localparam int unsigned CHAR_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam seg_t                  SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{SEG_ACTIVE_LOW}};

    logic [CNT_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FRM_W-1:0]      frm_q, frm_d;
    logic                  blink_on_q, blink_on_d;
    logic                  frame_done_q, frame_done_d;
    logic                  pending_q, pending_d;
    logic [CHAR_W-1:0]     act_char_q, act_char_d, pend_char_q, pend_char_d;
    logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic [NUM_DIGITS-1:0] act_blink_q, act_blink_d, pend_blink_q, pend_blink_d;
    seg_t                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  tick_c, wrap_c, dark_c;
    logic [3:0]            code_c;
    logic [NUM_DIGITS-1:0] sel_c;
    seg_t                  glyph_c, seg_hi_c;

    sev_seg_glyph u_glyph (
        .code  (code_c),
        .seg_c (glyph_c)
    );

    // Select the code, darkness and anode for the digit under scan.
    always_comb begin
        code_c = GLYPH_BLANK;
        dark_c = 1'b0;
        sel_c  = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                code_c   = act_char_q[4*i +: 4];
                dark_c   = act_blank_q[i] | (act_blink_q[i] & ~blink_on_q);
                sel_c[i] = 1'b1;
            end
        end
    end

    // frame_done is raised in the wrap-tick cycle itself, so the buffer swap
    // lands exactly at the edge where the index returns to digit 0.
    always_comb begin
        presc_d      = presc_q;
        idx_d        = idx_q;
        frm_d        = frm_q;
        blink_on_d   = blink_on_q;
        pending_d    = pending_q;
        act_char_d   = act_char_q;
        act_blank_d  = act_blank_q;
        act_blink_d  = act_blink_q;
        pend_char_d  = pend_char_q;
        pend_blank_d = pend_blank_q;
        pend_blink_d = pend_blink_q;

        tick_c       = (presc_q == CNT_W'(SCAN_DIV - 1));
        wrap_c       = (idx_q == IDX_W'(NUM_DIGITS - 1));
        frame_done_d = (presc_q == CNT_W'(SCAN_DIV - 2)) && wrap_c;

        if (tick_c) begin
            presc_d = '0;
            idx_d   = wrap_c ? '0 : idx_q + IDX_W'(1);
        end else begin
            presc_d = presc_q + CNT_W'(1);
        end

        if (frame_done_q) begin
            if (load) begin
                act_char_d  = char_in;
                act_blank_d = blank_mask;
                act_blink_d = blink_mask;
            end else if (pending_q) begin
                act_char_d  = pend_char_q;
                act_blank_d = pend_blank_q;
                act_blink_d = pend_blink_q;
            end
            pending_d = 1'b0;
            if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frm_d      = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end else if (load) begin
            pend_char_d  = char_in;
            pend_blank_d = blank_mask;
            pend_blink_d = blink_mask;
            pending_d    = 1'b1;
        end

        seg_hi_c = dark_c ? '0 : glyph_c;
        seg_d    = seg_hi_c ^ SEG_OFF;
        an_d     = tick_c ? AN_OFF : (sel_c ^ AN_OFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            frm_q        <= '0;
            blink_on_q   <= 1'b1;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            act_char_q   <= {NUM_DIGITS{GLYPH_BLANK}};
            act_blank_q  <= '0;
            act_blink_q  <= '0;
            pend_char_q  <= {NUM_DIGITS{GLYPH_BLANK}};
            pend_blank_q <= '0;
            pend_blink_q <= '0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frm_q        <= frm_d;
            blink_on_q   <= blink_on_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            act_char_q   <= act_char_d;
            act_blank_q  <= act_blank_d;
            act_blink_q  <= act_blink_d;
            pend_char_q  <= pend_char_d;
            pend_blank_q <= pend_blank_d;
            pend_blink_q <= pend_blink_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

`ifdef SEV_SEG_DP_EN
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                  dp_q, dp_d;

    // Decimal-point mask follows the same double-buffer path as the glyphs.
    always_comb begin
        act_dp_d  = act_dp_q;
        pend_dp_d = pend_dp_q;
        if (frame_done_q) begin
            if (load) begin
                act_dp_d = dp_mask;
            end else if (pending_q) begin
                act_dp_d = pend_dp_q;
            end
        end else if (load) begin
            pend_dp_d = dp_mask;
        end
        dp_d = SEG_ACTIVE_LOW;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                dp_d = (act_dp_q[i] & ~dark_c) ^ SEG_ACTIVE_LOW;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_dp_q  <= '0;
            pend_dp_q <= '0;
            dp_q      <= SEG_ACTIVE_LOW;
        end else begin
            act_dp_q  <= act_dp_d;
            pend_dp_q <= pend_dp_d;
            dp_q      <= dp_d;
        end
    end

    assign dp = dp_q;
`endif

endmodule

// File: tb/tb_sev_seg_scan.sv
// Directed bench for sev_seg_scan: 4 digits, 4-cycle slots, 2-frame blink.
module tb_sev_seg_scan;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned BF = 2;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] char_in;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;

    int errors = 0;
    int checks = 0;
    int fd_count;

    sev_seg_scan #(
        .NUM_DIGITS     (ND),
        .SCAN_DIV       (SD),
        .BLINK_FRAMES   (BF),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .char_in    (char_in),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame pulses seen since reset, used to predict the blink phase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          fd_count <= 0;
        else if (frame_done) fd_count <= fd_count + 1;
    end

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 64);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_frame_done: timeout, frame_done=%b want 1", frame_done);
        end
    endtask

    // Blank display scanning from the cycle after rst_n release.
    task automatic scan_blank(input int n);
        logic [3:0] one;
        logic [3:0] exp_an;
        logic       exp_fd;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            one    = 4'b0001 << ((c / 4) % 4);
            exp_an = ((c % 4) == 0) ? 4'hF : ~one;
            exp_fd = ((c % 16) == 15);
            checks++;
            if (an !== exp_an) begin
                errors++; $display("FAIL scan_an c=%0d: got %b want %b", c, an, exp_an);
            end
            checks++;
            if (seg !== 7'h7F) begin
                errors++; $display("FAIL scan_seg c=%0d: got %h want 7f", c, seg);
            end
            checks++;
            if (frame_done !== exp_fd) begin
                errors++; $display("FAIL scan_fd c=%0d: got %b want %b", c, frame_done, exp_fd);
            end
            checks++;
            if (pending !== 1'b0) begin
                errors++; $display("FAIL scan_pending c=%0d: got %b want 0", c, pending);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; char_in = '0; blank_mask = '0; blink_mask = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want 7f", seg); end
        checks++;
        if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pending); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        rst_n = 1'b1;
        scan_blank(32);
    endtask

    task automatic test_load_midframe();
        logic [6:0] exp_seg [4];
        logic [3:0] one;
        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        wait_fd();
        repeat (5) @(negedge clk);
        load = 1'b1; char_in = 16'h1234; blank_mask = '0; blink_mask = '0;
        @(negedge clk);
        load = 1'b0;
        for (int k = 6; k < 16; k++) begin
            checks++;
            if (pending !== 1'b1) begin errors++; $display("FAIL mid_pending k=%0d: got %b want 1", k, pending); end
            checks++;
            if (seg !== 7'h7F) begin errors++; $display("FAIL mid_old_frame k=%0d: got %h want 7f", k, seg); end
            @(negedge clk);
        end
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL mid_fd: got %b want 1", frame_done); end
        @(negedge clk);
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL mid_pending_clr: got %b want 0", pending); end
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            one = 4'b0001 << d;
            checks++;
            if (an !== ~one) begin errors++; $display("FAIL mid_an d=%0d: got %b want %b", d, an, ~one); end
            checks++;
            if (seg !== exp_seg[d]) begin errors++; $display("FAIL mid_seg d=%0d: got %h want %h", d, seg, exp_seg[d]); end
            if (d < 3) repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_load_on_boundary();
        logic [6:0] exp_seg [4];
        logic [3:0] one;
        exp_seg = '{7'h03, 7'h46, 7'h21, 7'h06};
        wait_fd();
        load = 1'b1; char_in = 16'hEDCB;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL bnd_pending: got %b want 0", pending); end
        checks++;
        if (an !== 4'hF) begin errors++; $display("FAIL bnd_gap_an: got %b want 1111", an); end
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            one = 4'b0001 << d;
            checks++;
            if (an !== ~one) begin errors++; $display("FAIL bnd_an d=%0d: got %b want %b", d, an, ~one); end
            checks++;
            if (seg !== exp_seg[d]) begin errors++; $display("FAIL bnd_seg d=%0d: got %h want %h", d, seg, exp_seg[d]); end
            if (d < 3) repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] one;
        wait_fd();
        repeat (2) @(negedge clk);
        load = 1'b1; char_in = 16'h1111;
        @(negedge clk);
        char_in = 16'h2222;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin errors++; $display("FAIL b2b_pending: got %b want 1", pending); end
        repeat (2) @(negedge clk);
        checks++;
        if (seg !== 7'h46) begin errors++; $display("FAIL b2b_old_frame: got %h want 46", seg); end
        repeat (10) @(negedge clk);
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_fd: got %b want 1", frame_done); end
        @(negedge clk);
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL b2b_pending_clr: got %b want 0", pending); end
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            one = 4'b0001 << d;
            checks++;
            if (an !== ~one) begin errors++; $display("FAIL b2b_an d=%0d: got %b want %b", d, an, ~one); end
            checks++;
            if (seg !== 7'h24) begin errors++; $display("FAIL b2b_seg d=%0d: got %h want 24", d, seg); end
            if (d < 3) repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_blink_blank();
        logic       exp_on;
        logic [6:0] exp_d0;
        wait_fd();
        load = 1'b1; char_in = 16'h8888; blink_mask = 4'b0001; blank_mask = 4'b0010;
        @(negedge clk);
        load = 1'b0; blink_mask = '0; blank_mask = '0;
        for (int f = 0; f < 4; f++) begin
            exp_on = (((fd_count / 2) % 2) == 0);
            exp_d0 = exp_on ? 7'h00 : 7'h7F;
            @(negedge clk);
            checks++;
            if (an !== 4'b1110) begin errors++; $display("FAIL blink_an0 f=%0d: got %b want 1110", f, an); end
            checks++;
            if (seg !== exp_d0) begin errors++; $display("FAIL blink_seg0 f=%0d: got %h want %h", f, seg, exp_d0); end
            repeat (4) @(negedge clk);
            checks++;
            if (an !== 4'b1101) begin errors++; $display("FAIL blank_an1 f=%0d: got %b want 1101", f, an); end
            checks++;
            if (seg !== 7'h7F) begin errors++; $display("FAIL blank_seg1 f=%0d: got %h want 7f", f, seg); end
            repeat (4) @(negedge clk);
            checks++;
            if (seg !== 7'h00) begin errors++; $display("FAIL blink_seg2 f=%0d: got %h want 00", f, seg); end
            repeat (6) @(negedge clk);
            checks++;
            if (frame_done !== 1'b1) begin errors++; $display("FAIL blink_fd f=%0d: got %b want 1", f, frame_done); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midframe();
        wait_fd();
        @(negedge clk);
        load = 1'b1; char_in = 16'h1234; blank_mask = '0; blink_mask = '0;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin errors++; $display("FAIL rstmid_pending_pre: got %b want 1", pending); end
        checks++;
        if (an !== 4'b1110) begin errors++; $display("FAIL rstmid_an_pre: got %b want 1110", an); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg !== 7'h7F) begin errors++; $display("FAIL rstmid_seg: got %h want 7f", seg); end
        checks++;
        if (an !== 4'hF) begin errors++; $display("FAIL rstmid_an: got %b want 1111", an); end
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got %b want 0", pending); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_fd: got %b want 0", frame_done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        scan_blank(32);
    endtask

    initial begin
        test_reset();
        test_load_midframe();
        test_load_on_boundary();
        test_back_to_back();
        test_blink_blank();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
